// File: rtl/bp_stream_axil_bridge.sv
// Purpose: AXI-Lite slave bridging single-beat writes to a host-to-BP stream word
//          and BP-to-host stream words into a small receive FIFO drained by AXI-Lite reads.
// Latency: AW+W complete -> stream_v_o 1 cycle; AR handshake -> rvalid_o 1 cycle.
// Backpressure: one write and one read outstanding; stream_ready_o drops while the receive FIFO is full.
// Ports: clk_i/reset_n_i (async active-low); s_axil_* AXI-Lite slave;
//        stream_v_o/addr_o/data_o/yumi_i outbound word; stream_v_i/data_i/ready_o inbound word.

module bp_stream_axil_bridge_fifo #(
  parameter int width_p = 32,
  parameter int els_p   = 4
) (
  input  logic                       clk_i,
  input  logic                       reset_n_i,
  input  logic                       v_i,
  input  logic [width_p-1:0]         data_i,
  output logic                       ready_o,
  output logic                       v_o,
  output logic [width_p-1:0]         data_o,
  input  logic                       yumi_i,
  output logic [$clog2(els_p):0]     count_o
);
  // Purpose: power-of-two circular FIFO with an occupancy count.
  // Latency: a pushed word is visible at the head the following cycle.
  // Backpressure: ready_o is registered and low while full (and while in reset).

  localparam int ptr_w_lp = $clog2(els_p);
  localparam int cnt_w_lp = ptr_w_lp + 1;

  logic [width_p-1:0]  mem_q [els_p];
  logic [ptr_w_lp-1:0] wr_ptr_q, wr_ptr_d;
  logic [ptr_w_lp-1:0] rd_ptr_q, rd_ptr_d;
  logic [cnt_w_lp-1:0] count_q, count_d;
  logic                ready_q, ready_d;
  logic                push, pop;

  assign push = v_i & ready_q;
  assign pop  = yumi_i & (count_q != '0);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + ptr_w_lp'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + ptr_w_lp'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + cnt_w_lp'(1);
      2'b01:   count_d = count_q - cnt_w_lp'(1);
      default: count_d = count_q;
    endcase
    // Ready is registered so it reads low throughout reset.
    ready_d = (count_d != cnt_w_lp'(els_p));
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ready_q  <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ready_q  <= ready_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= data_i;
  end

  assign ready_o = ready_q;
  assign v_o     = (count_q != '0);
  assign data_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;
endmodule

module bp_stream_axil_bridge #(
  parameter int addr_width_p = 32,
  parameter int data_width_p = 32,
  parameter int rx_els_p     = 4
) (
  input  logic                      clk_i,
  input  logic                      reset_n_i,
  input  logic [addr_width_p-1:0]   s_axil_awaddr_i,
  input  logic [2:0]                s_axil_awprot_i,
  input  logic                      s_axil_awvalid_i,
  output logic                      s_axil_awready_o,
  input  logic [data_width_p-1:0]   s_axil_wdata_i,
  input  logic [data_width_p/8-1:0] s_axil_wstrb_i,
  input  logic                      s_axil_wvalid_i,
  output logic                      s_axil_wready_o,
  output logic [1:0]                s_axil_bresp_o,
  output logic                      s_axil_bvalid_o,
  input  logic                      s_axil_bready_i,
  input  logic [addr_width_p-1:0]   s_axil_araddr_i,
  input  logic [2:0]                s_axil_arprot_i,
  input  logic                      s_axil_arvalid_i,
  output logic                      s_axil_arready_o,
  output logic [data_width_p-1:0]   s_axil_rdata_o,
  output logic [1:0]                s_axil_rresp_o,
  output logic                      s_axil_rvalid_o,
  input  logic                      s_axil_rready_i,
  output logic                      stream_v_o,
  output logic [addr_width_p-1:0]   stream_addr_o,
  output logic [data_width_p-1:0]   stream_data_o,
  input  logic                      stream_yumi_i,
  input  logic                      stream_v_i,
  input  logic [data_width_p-1:0]   stream_data_i,
  output logic                      stream_ready_o
);

  localparam int cnt_w_lp = $clog2(rx_els_p) + 1;
  localparam logic [1:0] resp_okay_lp   = 2'b00;
  localparam logic [1:0] resp_slverr_lp = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_SEND, W_RESP} w_state_e;
  typedef enum logic       {R_IDLE, R_RESP}         r_state_e;

  // Protection bits and the upper read-address bits carry no meaning here.
  logic unused_ok;
  assign unused_ok = ^{s_axil_awprot_i, s_axil_arprot_i, s_axil_araddr_i[addr_width_p-1:8]};

  // ---------------- write path ----------------
  w_state_e                w_state_q, w_state_d;
  logic                    aw_got_q, aw_got_d;
  logic                    w_got_q, w_got_d;
  logic                    strb_ok_q, strb_ok_d;
  logic [addr_width_p-1:0] waddr_q, waddr_d;
  logic [data_width_p-1:0] wdata_q, wdata_d;
  logic                    awready_q, awready_d;
  logic                    wready_q, wready_d;
  logic                    bvalid_q, bvalid_d;
  logic [1:0]              bresp_q, bresp_d;
  logic                    stream_v_q, stream_v_d;
  logic                    aw_hs, w_hs;

  assign aw_hs = s_axil_awvalid_i & awready_q;
  assign w_hs  = s_axil_wvalid_i & wready_q;

  always_comb begin
    w_state_d  = w_state_q;
    aw_got_d   = aw_got_q;
    w_got_d    = w_got_q;
    strb_ok_d  = strb_ok_q;
    waddr_d    = waddr_q;
    wdata_d    = wdata_q;
    bvalid_d   = bvalid_q;
    bresp_d    = bresp_q;
    stream_v_d = stream_v_q;
    case (w_state_q)
      W_IDLE: begin
        if (aw_hs) begin
          aw_got_d = 1'b1;
          waddr_d  = s_axil_awaddr_i;
        end
        if (w_hs) begin
          w_got_d   = 1'b1;
          wdata_d   = s_axil_wdata_i;
          strb_ok_d = &s_axil_wstrb_i;
        end
        if (aw_got_d && w_got_d) begin
          aw_got_d = 1'b0;
          w_got_d  = 1'b0;
          // Partial-strobe writes cannot be represented as a stream word.
          if (strb_ok_d) begin
            w_state_d  = W_SEND;
            stream_v_d = 1'b1;
          end else begin
            w_state_d = W_RESP;
            bvalid_d  = 1'b1;
            bresp_d   = resp_slverr_lp;
          end
        end
      end
      W_SEND: begin
        if (stream_yumi_i) begin
          w_state_d  = W_RESP;
          stream_v_d = 1'b0;
          bvalid_d   = 1'b1;
          bresp_d    = resp_okay_lp;
        end
      end
      W_RESP: begin
        if (s_axil_bready_i) begin
          w_state_d = W_IDLE;
          bvalid_d  = 1'b0;
        end
      end
      default: w_state_d = W_IDLE;
    endcase
    awready_d = (w_state_d == W_IDLE) & ~aw_got_d;
    wready_d  = (w_state_d == W_IDLE) & ~w_got_d;
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      w_state_q  <= W_IDLE;
      aw_got_q   <= 1'b0;
      w_got_q    <= 1'b0;
      strb_ok_q  <= 1'b0;
      waddr_q    <= '0;
      wdata_q    <= '0;
      awready_q  <= 1'b0;
      wready_q   <= 1'b0;
      bvalid_q   <= 1'b0;
      bresp_q    <= 2'b00;
      stream_v_q <= 1'b0;
    end else begin
      w_state_q  <= w_state_d;
      aw_got_q   <= aw_got_d;
      w_got_q    <= w_got_d;
      strb_ok_q  <= strb_ok_d;
      waddr_q    <= waddr_d;
      wdata_q    <= wdata_d;
      awready_q  <= awready_d;
      wready_q   <= wready_d;
      bvalid_q   <= bvalid_d;
      bresp_q    <= bresp_d;
      stream_v_q <= stream_v_d;
    end
  end

  // ---------------- receive FIFO ----------------
  logic                    fifo_v, fifo_yumi, fifo_ready;
  logic [data_width_p-1:0] fifo_data;
  logic [cnt_w_lp-1:0]     fifo_count;

  bp_stream_axil_bridge_fifo #(
    .width_p (data_width_p),
    .els_p   (rx_els_p)
  ) rx_fifo (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .v_i       (stream_v_i),
    .data_i    (stream_data_i),
    .ready_o   (fifo_ready),
    .v_o       (fifo_v),
    .data_o    (fifo_data),
    .yumi_i    (fifo_yumi),
    .count_o   (fifo_count)
  );

  // ---------------- read path ----------------
  r_state_e                r_state_q, r_state_d;
  logic                    arready_q, arready_d;
  logic                    rvalid_q, rvalid_d;
  logic [data_width_p-1:0] rdata_q, rdata_d;
  logic [1:0]              rresp_q, rresp_d;
  logic                    ar_hs;

  assign ar_hs = s_axil_arvalid_i & arready_q;

  always_comb begin
    r_state_d = r_state_q;
    rvalid_d  = rvalid_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    fifo_yumi = 1'b0;
    case (r_state_q)
      R_IDLE: begin
        if (ar_hs) begin
          r_state_d = R_RESP;
          rvalid_d  = 1'b1;
          rdata_d   = '0;
          rresp_d   = resp_okay_lp;
          case (s_axil_araddr_i[7:0])
            8'h20: begin
              // Head is captured and popped in the AR cycle itself.
              if (fifo_v) begin
                rdata_d   = fifo_data;
                fifo_yumi = 1'b1;
              end else begin
                rresp_d = resp_slverr_lp;
              end
            end
            8'h24:   rdata_d = data_width_p'(fifo_count);
            default: rdata_d = '0;
          endcase
        end
      end
      R_RESP: begin
        if (s_axil_rready_i) begin
          r_state_d = R_IDLE;
          rvalid_d  = 1'b0;
        end
      end
      default: r_state_d = R_IDLE;
    endcase
    arready_d = (r_state_d == R_IDLE);
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_state_q <= R_IDLE;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= 2'b00;
    end else begin
      r_state_q <= r_state_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
    end
  end

  assign s_axil_awready_o = awready_q;
  assign s_axil_wready_o  = wready_q;
  assign s_axil_bvalid_o  = bvalid_q;
  assign s_axil_bresp_o   = bresp_q;
  assign s_axil_arready_o = arready_q;
  assign s_axil_rvalid_o  = rvalid_q;
  assign s_axil_rdata_o   = rdata_q;
  assign s_axil_rresp_o   = rresp_q;
  assign stream_v_o       = stream_v_q;
  assign stream_addr_o    = waddr_q;
  assign stream_data_o    = wdata_q;
  assign stream_ready_o   = fifo_ready;
endmodule

// File: tb/tb_bp_stream_axil_bridge.sv
// Purpose: self-checking bench for bp_stream_axil_bridge: directed scenarios plus randomized traffic.
// Latency: a transaction-level model predicts every output each cycle.
// Backpressure: random ready/yumi/valid patterns stall both paths independently.

module tb_bp_stream_axil_bridge;
  localparam int RX = 4;

  logic        clk_i = 1'b0;
  logic        reset_n_i = 1'b0;
  logic [31:0] s_axil_awaddr_i = '0;
  logic [2:0]  s_axil_awprot_i = '0;
  logic        s_axil_awvalid_i = 1'b0;
  logic        s_axil_awready_o;
  logic [31:0] s_axil_wdata_i = '0;
  logic [3:0]  s_axil_wstrb_i = '0;
  logic        s_axil_wvalid_i = 1'b0;
  logic        s_axil_wready_o;
  logic [1:0]  s_axil_bresp_o;
  logic        s_axil_bvalid_o;
  logic        s_axil_bready_i = 1'b0;
  logic [31:0] s_axil_araddr_i = '0;
  logic [2:0]  s_axil_arprot_i = '0;
  logic        s_axil_arvalid_i = 1'b0;
  logic        s_axil_arready_o;
  logic [31:0] s_axil_rdata_o;
  logic [1:0]  s_axil_rresp_o;
  logic        s_axil_rvalid_o;
  logic        s_axil_rready_i = 1'b0;
  logic        stream_v_o;
  logic [31:0] stream_addr_o;
  logic [31:0] stream_data_o;
  logic        stream_yumi_i = 1'b0;
  logic        stream_v_i = 1'b0;
  logic [31:0] stream_data_i = '0;
  logic        stream_ready_o;

  int checks = 0;
  int errors = 0;

  always #5 clk_i = ~clk_i;

  bp_stream_axil_bridge dut (
    .clk_i (clk_i), .reset_n_i (reset_n_i),
    .s_axil_awaddr_i (s_axil_awaddr_i), .s_axil_awprot_i (s_axil_awprot_i),
    .s_axil_awvalid_i (s_axil_awvalid_i), .s_axil_awready_o (s_axil_awready_o),
    .s_axil_wdata_i (s_axil_wdata_i), .s_axil_wstrb_i (s_axil_wstrb_i),
    .s_axil_wvalid_i (s_axil_wvalid_i), .s_axil_wready_o (s_axil_wready_o),
    .s_axil_bresp_o (s_axil_bresp_o), .s_axil_bvalid_o (s_axil_bvalid_o),
    .s_axil_bready_i (s_axil_bready_i),
    .s_axil_araddr_i (s_axil_araddr_i), .s_axil_arprot_i (s_axil_arprot_i),
    .s_axil_arvalid_i (s_axil_arvalid_i), .s_axil_arready_o (s_axil_arready_o),
    .s_axil_rdata_o (s_axil_rdata_o), .s_axil_rresp_o (s_axil_rresp_o),
    .s_axil_rvalid_o (s_axil_rvalid_o), .s_axil_rready_i (s_axil_rready_i),
    .stream_v_o (stream_v_o), .stream_addr_o (stream_addr_o),
    .stream_data_o (stream_data_o), .stream_yumi_i (stream_yumi_i),
    .stream_v_i (stream_v_i), .stream_data_i (stream_data_i),
    .stream_ready_o (stream_ready_o)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic timeout(input string nm);
    checks++;
    errors++;
    $display("FAIL %s: actual=no handshake required=handshake within 50 cycles", nm);
  endtask

  // ---------------- behavioural model ----------------
  // wphase: 0 = accepting AW/W, 1 = word offered on stream, 2 = response pending
  int          wphase;
  bit          got_aw, got_w, m_strb_ok, rbusy, m_live;
  logic [31:0] m_waddr, m_wdata, m_rdata;
  logic [1:0]  m_bresp, m_rresp;
  logic [31:0] q[$];

  function automatic bit e_awready(); return m_live && wphase == 0 && !got_aw; endfunction
  function automatic bit e_wready();  return m_live && wphase == 0 && !got_w;  endfunction
  function automatic bit e_arready(); return m_live && !rbusy; endfunction
  function automatic bit e_sready();  return m_live && q.size() < RX; endfunction

  task automatic m_clear();
    wphase = 0; got_aw = 0; got_w = 0; m_strb_ok = 0; rbusy = 0; m_live = 0;
    m_waddr = '0; m_wdata = '0; m_rdata = '0; m_bresp = '0; m_rresp = '0;
    q.delete();
  endtask

  task automatic m_step();
    bit aw_hs, w_hs, ar_hs, push, yumi_ok, b_hs, r_done;
    aw_hs   = s_axil_awvalid_i && e_awready();
    w_hs    = s_axil_wvalid_i && e_wready();
    ar_hs   = s_axil_arvalid_i && e_arready();
    push    = stream_v_i && e_sready();
    yumi_ok = stream_yumi_i && wphase == 1;
    b_hs    = s_axil_bready_i && wphase == 2;
    r_done  = s_axil_rready_i && rbusy;
    if (wphase == 0) begin
      if (aw_hs) begin got_aw = 1; m_waddr = s_axil_awaddr_i; end
      if (w_hs) begin got_w = 1; m_wdata = s_axil_wdata_i; m_strb_ok = (s_axil_wstrb_i == 4'hF); end
      if (got_aw && got_w) begin
        got_aw = 0; got_w = 0;
        if (m_strb_ok) wphase = 1;
        else begin wphase = 2; m_bresp = 2'b10; end
      end
    end else if (wphase == 1) begin
      if (yumi_ok) begin wphase = 2; m_bresp = 2'b00; end
    end else if (b_hs) begin
      wphase = 0;
    end
    if (ar_hs) begin
      rbusy = 1; m_rdata = '0; m_rresp = 2'b00;
      if (s_axil_araddr_i[7:0] == 8'h20) begin
        if (q.size() > 0) m_rdata = q.pop_front();
        else m_rresp = 2'b10;
      end else if (s_axil_araddr_i[7:0] == 8'h24) begin
        m_rdata = q.size();
      end
    end else if (r_done) begin
      rbusy = 0;
    end
    if (push) q.push_back(stream_data_i);
    m_live = 1;
  endtask

  initial begin
    m_clear();
    forever begin
      @(posedge clk_i or negedge reset_n_i);
      if (!reset_n_i) m_clear();
      else m_step();
    end
  end

  // ---------------- per-cycle compare ----------------
  initial begin
    forever begin
      @(negedge clk_i);
      chk("awready", s_axil_awready_o, e_awready());
      chk("wready", s_axil_wready_o, e_wready());
      chk("arready", s_axil_arready_o, e_arready());
      chk("stream_ready", stream_ready_o, e_sready());
      chk("bvalid", s_axil_bvalid_o, wphase == 2);
      chk("rvalid", s_axil_rvalid_o, rbusy);
      chk("stream_v", stream_v_o, wphase == 1);
      if (!reset_n_i) begin
        chk("rst_bresp", s_axil_bresp_o, 0);
        chk("rst_rresp", s_axil_rresp_o, 0);
        chk("rst_rdata", s_axil_rdata_o, 0);
        chk("rst_saddr", stream_addr_o, 0);
        chk("rst_sdata", stream_data_o, 0);
      end
      if (wphase == 2) chk("bresp", s_axil_bresp_o, m_bresp);
      if (rbusy) begin
        chk("rdata", s_axil_rdata_o, m_rdata);
        chk("rresp", s_axil_rresp_o, m_rresp);
      end
      if (wphase == 1) begin
        chk("stream_addr", stream_addr_o, m_waddr);
        chk("stream_data", stream_data_o, m_wdata);
      end
    end
  end

  // ---------------- drivers ----------------
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic send_aw(input logic [31:0] a);
    s_axil_awaddr_i = a; s_axil_awvalid_i = 1;
    for (int i = 0; i < 50; i++) begin
      if (s_axil_awready_o) begin step(); s_axil_awvalid_i = 0; return; end
      step();
    end
    s_axil_awvalid_i = 0; timeout("aw_handshake");
  endtask

  task automatic send_w(input logic [31:0] d, input logic [3:0] s);
    s_axil_wdata_i = d; s_axil_wstrb_i = s; s_axil_wvalid_i = 1;
    for (int i = 0; i < 50; i++) begin
      if (s_axil_wready_o) begin step(); s_axil_wvalid_i = 0; return; end
      step();
    end
    s_axil_wvalid_i = 0; timeout("w_handshake");
  endtask

  task automatic send_aw_w(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    s_axil_awaddr_i = a; s_axil_wdata_i = d; s_axil_wstrb_i = s;
    s_axil_awvalid_i = 1; s_axil_wvalid_i = 1;
    for (int i = 0; i < 50; i++) begin
      if (s_axil_awready_o && s_axil_wready_o) begin
        step(); s_axil_awvalid_i = 0; s_axil_wvalid_i = 0; return;
      end
      step();
    end
    s_axil_awvalid_i = 0; s_axil_wvalid_i = 0; timeout("aw_w_handshake");
  endtask

  task automatic push_word(input logic [31:0] d);
    stream_data_i = d; stream_v_i = 1;
    for (int i = 0; i < 50; i++) begin
      if (stream_ready_o) begin step(); stream_v_i = 0; return; end
      step();
    end
    stream_v_i = 0; timeout("push_handshake");
  endtask

  task automatic send_ar(input logic [31:0] a);
    s_axil_araddr_i = a; s_axil_arvalid_i = 1;
    for (int i = 0; i < 50; i++) begin
      if (s_axil_arready_o) begin step(); s_axil_arvalid_i = 0; return; end
      step();
    end
    s_axil_arvalid_i = 0; timeout("ar_handshake");
  endtask

  task automatic get_r(input int hold, output logic [31:0] d, output logic [1:0] r);
    d = 'x; r = 'x;
    for (int i = 0; i < 50; i++) begin
      if (s_axil_rvalid_o) begin
        repeat (hold) step();
        d = s_axil_rdata_o; r = s_axil_rresp_o;
        s_axil_rready_i = 1; step(); s_axil_rready_i = 0;
        return;
      end
      step();
    end
    timeout("rvalid_wait");
  endtask

  task automatic axi_read(input logic [31:0] a, input int hold, output logic [31:0] d, output logic [1:0] r);
    send_ar(a);
    get_r(hold, d, r);
  endtask

  task automatic get_b(output logic [1:0] r);
    r = 'x;
    for (int i = 0; i < 50; i++) begin
      if (s_axil_bvalid_o) begin
        r = s_axil_bresp_o;
        s_axil_bready_i = 1; step(); s_axil_bready_i = 0;
        return;
      end
      step();
    end
    timeout("bvalid_wait");
  endtask

  initial begin
    logic [31:0] d;
    logic [1:0]  r;
    logic [31:0] rnd;
    logic [7:0]  lo;

    // reset state and first cycle after release
    repeat (3) step();
    chk("lit_rst_awready", s_axil_awready_o, 0);
    chk("lit_rst_stream_ready", stream_ready_o, 0);
    reset_n_i = 1;
    step();
    chk("lit_post_awready", s_axil_awready_o, 1);
    chk("lit_post_wready", s_axil_wready_o, 1);
    chk("lit_post_arready", s_axil_arready_o, 1);
    chk("lit_post_stream_ready", stream_ready_o, 1);

    // AW then W two cycles later, yumi after 3 cycles
    send_aw(32'h10);
    step();
    send_w(32'hDEADBEEF, 4'hF);
    chk("lit_w1_stream_v", stream_v_o, 1);
    chk("lit_w1_addr", stream_addr_o, 32'h10);
    chk("lit_w1_data", stream_data_o, 32'hDEADBEEF);
    repeat (3) step();
    chk("lit_w1_stream_v_held", stream_v_o, 1);
    stream_yumi_i = 1; step(); stream_yumi_i = 0;
    chk("lit_w1_bvalid", s_axil_bvalid_o, 1);
    chk("lit_w1_bresp", s_axil_bresp_o, 2'b00);
    chk("lit_w1_stream_v_drop", stream_v_o, 0);
    get_b(r);

    // partial strobe: no stream word, SLVERR
    send_aw_w(32'h14, 32'h1234, 4'h3);
    chk("lit_w2_stream_v", stream_v_o, 0);
    chk("lit_w2_bvalid", s_axil_bvalid_o, 1);
    chk("lit_w2_bresp", s_axil_bresp_o, 2'b10);
    get_b(r);

    // fill the receive FIFO, then drain it
    for (int i = 1; i <= 4; i++) push_word(i);
    chk("lit_full_ready", stream_ready_o, 0);
    axi_read(32'h24, 0, d, r);
    chk("lit_count4", d, 4);
    chk("lit_count4_resp", r, 0);
    for (int i = 1; i <= 4; i++) begin
      axi_read(32'h20, 0, d, r);
      chk("lit_pop_data", d, i);
      chk("lit_pop_resp", r, 0);
    end
    axi_read(32'h20, 0, d, r);
    chk("lit_empty_data", d, 0);
    chk("lit_empty_resp", r, 2'b10);

    // push and pop in the same cycle
    push_word(32'hA);
    push_word(32'hB);
    stream_data_i = 32'hC; stream_v_i = 1;
    s_axil_araddr_i = 32'h20; s_axil_arvalid_i = 1;
    step();
    stream_v_i = 0; s_axil_arvalid_i = 0;
    get_r(0, d, r);
    chk("lit_pp_head", d, 32'hA);
    axi_read(32'h24, 0, d, r);
    chk("lit_pp_count", d, 2);
    axi_read(32'h20, 0, d, r);
    chk("lit_pp_b", d, 32'hB);
    axi_read(32'h20, 0, d, r);
    chk("lit_pp_c", d, 32'hC);

    // stalled write with a concurrent stalled read
    push_word(32'h77);
    send_aw_w(32'h40, 32'hCAFEF00D, 4'hF);
    chk("lit_stall_stream_v", stream_v_o, 1);
    axi_read(32'h24, 5, d, r);
    chk("lit_stall_count", d, 1);
    chk("lit_stall_count_resp", r, 0);
    repeat (3) step();
    chk("lit_stall_v_held", stream_v_o, 1);
    chk("lit_stall_addr", stream_addr_o, 32'h40);
    chk("lit_stall_data", stream_data_o, 32'hCAFEF00D);
    stream_yumi_i = 1; step(); stream_yumi_i = 0;
    get_b(r);
    chk("lit_stall_bresp", r, 2'b00);
    axi_read(32'h20, 0, d, r);
    chk("lit_stall_pop", d, 32'h77);

    // reset in the middle of a stream offer with FIFO holding 3
    for (int i = 5; i <= 7; i++) push_word(i);
    send_aw_w(32'h80, 32'h99, 4'hF);
    chk("lit_mid_stream_v", stream_v_o, 1);
    #2 reset_n_i = 0;
    #1;
    chk("lit_mid_rst_stream_v", stream_v_o, 0);
    chk("lit_mid_rst_stream_ready", stream_ready_o, 0);
    chk("lit_mid_rst_awready", s_axil_awready_o, 0);
    step();
    reset_n_i = 1;
    step();
    chk("lit_rel_awready", s_axil_awready_o, 1);
    chk("lit_rel_wready", s_axil_wready_o, 1);
    chk("lit_rel_arready", s_axil_arready_o, 1);
    chk("lit_rel_stream_ready", stream_ready_o, 1);
    chk("lit_rel_stream_v", stream_v_o, 0);
    axi_read(32'h24, 0, d, r);
    chk("lit_rel_count", d, 0);

    // randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      rnd = $urandom;
      s_axil_awvalid_i = ($urandom_range(0, 2) == 0);
      s_axil_awaddr_i  = $urandom;
      s_axil_awprot_i  = 3'($urandom_range(0, 7));
      s_axil_wvalid_i  = ($urandom_range(0, 2) == 0);
      s_axil_wdata_i   = $urandom;
      s_axil_wstrb_i   = ($urandom_range(0, 3) != 0) ? 4'hF : 4'($urandom_range(0, 14));
      s_axil_bready_i  = ($urandom_range(0, 1) == 1);
      case ($urandom_range(0, 3))
        0, 2:    lo = 8'h20;
        1:       lo = 8'h24;
        default: lo = rnd[7:0];
      endcase
      s_axil_araddr_i  = {rnd[31:8], lo};
      s_axil_arprot_i  = 3'($urandom_range(0, 7));
      s_axil_arvalid_i = ($urandom_range(0, 2) == 0);
      s_axil_rready_i  = ($urandom_range(0, 1) == 1);
      stream_yumi_i    = ($urandom_range(0, 2) == 0);
      stream_v_i       = ($urandom_range(0, 1) == 1);
      stream_data_i    = $urandom;
      if (i == 1500) begin
        reset_n_i = 0;
        step();
        step();
        reset_n_i = 1;
      end
      step();
    end

    s_axil_awvalid_i = 0; s_axil_wvalid_i = 0; s_axil_arvalid_i = 0;
    stream_v_i = 0; stream_yumi_i = 0; s_axil_bready_i = 1; s_axil_rready_i = 1;
    repeat (5) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/bp_stream_axil_bridge.md
BP_STREAM_AXIL_BRIDGE -- requirements
Module: bp_stream_axil_bridge

Interface
REQ-001 SHALL have parameter addr_width_p, default 32, meaning AXI-Lite and stream address width.
REQ-002 SHALL have parameter data_width_p, default 32, meaning AXI-Lite and stream data width; strobe width is data_width_p/8.
REQ-003 SHALL have parameter rx_els_p, default 4, meaning receive FIFO depth (power of two, >=2).
REQ-004 clk_i  input  1  sole clock; all state rising-edge.
REQ-005 reset_n_i  input  1  asynchronous, active-low reset.
REQ-006 s_axil_awaddr_i/awprot_i/awvalid_i  input  addr_width_p/3/1; s_axil_awready_o  output  1.
REQ-007 s_axil_wdata_i/wstrb_i/wvalid_i  input  data_width_p/data_width_p/8/1; s_axil_wready_o  output  1.
REQ-008 s_axil_bresp_o  output  2; s_axil_bvalid_o  output  1; s_axil_bready_i  input  1.
REQ-009 s_axil_araddr_i/arprot_i/arvalid_i  input  addr_width_p/3/1; s_axil_arready_o  output  1.
REQ-010 s_axil_rdata_o/rresp_o/rvalid_o  output  data_width_p/2/1; s_axil_rready_i  input  1.
REQ-011 stream_v_o  output  1; stream_addr_o  output  addr_width_p; stream_data_o  output  data_width_p; stream_yumi_i  input  1 (host-to-BP word, consumed on yumi).
REQ-012 stream_v_i  input  1; stream_data_i  input  data_width_p; stream_ready_o  output  1 (BP-to-host word, accepted on v&ready).

Function
REQ-013 Write path SHALL be a 3-state FSM: W_IDLE, W_SEND, W_RESP.
REQ-014 W_IDLE: awready_o=1 until AW captured, wready_o=1 until W captured; AW and W SHALL be accepted independently, in either order or same cycle.
REQ-015 When both captured and wstrb == all ones, SHALL go to W_SEND next cycle; stream_v_o=1 with registered addr/data held stable until stream_yumi_i.
REQ-016 stream_yumi_i in W_SEND SHALL move to W_RESP next cycle with bresp=OKAY (2'b00); stream_yumi_i while stream_v_o=0 SHALL be ignored.
REQ-017 When both captured and wstrb != all ones, SHALL skip W_SEND, emit no stream word, go to W_RESP with bresp=SLVERR (2'b10).
REQ-018 W_RESP: bvalid_o=1 until bready_i, then W_IDLE; awready_o=wready_o=0 outside W_IDLE-uncaptured; one outstanding write max.
REQ-019 Receive FIFO of rx_els_p entries: stream_ready_o = ~full; push on stream_v_i&stream_ready_o.
REQ-020 Read path SHALL be 2-state FSM R_IDLE (arready_o=1), R_RESP (rvalid_o=1, held until rready_i, then R_IDLE).
REQ-021 Read araddr[7:0]==8'h20, FIFO non-empty: rdata=head, rresp=OKAY, pop on the AR handshake cycle.
REQ-022 Read 8'h20, FIFO empty: rdata=0, rresp=SLVERR, no pop.
REQ-023 Read 8'h24: rdata = occupancy count zero-extended (0..rx_els_p), rresp=OKAY; count sampled at AR handshake.
REQ-024 Any other read address: rdata=0, rresp=OKAY.
REQ-025 Simultaneous push and pop SHALL keep occupancy unchanged; push when full SHALL not occur (ready low); pointers wrap modulo rx_els_p, occupancy counter is $clog2(rx_els_p)+1 bits.
REQ-026 Read and write paths SHALL operate concurrently and independently; awprot/arprot ignored.
REQ-027 Write latency: AW+W complete to stream_v_o = 1 cycle; read latency: AR handshake to rvalid_o = 1 cycle.

Reset
REQ-028 reset_n_i low SHALL asynchronously force W_IDLE, R_IDLE, FIFO empty, capture flags cleared.
REQ-029 During reset: awready_o=wready_o=arready_o=0, bvalid_o=rvalid_o=stream_v_o=0, stream_ready_o=0, bresp/rresp/rdata/stream_addr/stream_data=0.
REQ-030 Reset mid-transaction SHALL drop any pending write/read and FIFO contents without emitting a stream word; first cycle after release, awready_o=wready_o=arready_o=stream_ready_o=1.

Verification
REQ-031 AW 0x10 then W 0xDEADBEEF strb 4'hF two cycles later -> stream_v_o with addr 0x10 data 0xDEADBEEF; yumi after 3 cycles -> bvalid, bresp 00.
REQ-032 AW+W same cycle strb 4'h3 -> no stream_v_o, bresp 2'b10.
REQ-033 Push 4 words 1,2,3,4 -> stream_ready_o=0; read 0x24 -> 4; four reads 0x20 -> 1,2,3,4 OKAY; fifth -> 0, SLVERR.
REQ-034 FIFO holding 2, push and AR-pop same cycle -> read 0x24 next returns 2.
REQ-035 Hold stream_yumi_i low 10 cycles in W_SEND, rready_i low 5 cycles in R_RESP -> outputs stable; concurrent read completes unaffected by stalled write.
REQ-036 Assert reset_n_i low during W_SEND with FIFO holding 3 -> stream_v_o=0 immediately; after release read 0x24 -> 0.
